// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequences DIV/DIVU between the E stage and the multi-cycle div core.
// Define DIV_ZERO_FAST_EN to answer divide-by-zero without running the core.
module div_seq_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_op_div,
  input  logic               i_op_signed,
  input  logic [WIDTH-1:0]   i_src_a,
  input  logic [WIDTH-1:0]   i_src_b,
  input  logic               i_flush,
  input  logic               i_ex_adv,
  input  logic [2*WIDTH-1:0] i_core_result,
  input  logic               i_core_ready,
  output logic               o_core_start,
  output logic               o_core_signed,
  output logic [WIDTH-1:0]   o_core_a,
  output logic [WIDTH-1:0]   o_core_b,
  output logic               o_core_annul,
  output logic               o_div_stall,
  output logic               o_hilo_we,
  output logic [2*WIDTH-1:0] o_hilo_wdata,
  output logic               o_div_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_res;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_start, r_signed, r_err;
  logic               w_go, w_fast, w_tmo;
  assign w_go = r_state == IDLE && i_op_div && !i_flush;
`ifdef DIV_ZERO_FAST_EN
  assign w_fast = w_go && i_src_b == '0;
`else
  assign w_fast = 1'b0;
`endif
  // flush and ready both outrank the watchdog in the same cycle
  assign w_tmo = r_state == BUSY && !i_flush && !i_core_ready && r_cnt == CW'(MAX_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_res    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_start  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
    end else
      case (r_state)
        IDLE: if (w_go) begin
          r_a      <= i_src_a;
          r_b      <= i_src_b;
          r_signed <= i_op_signed;
          r_cnt    <= '0;
          r_start  <= !w_fast;
          r_res    <= w_fast ? {i_src_a, {WIDTH{1'b1}}} : r_res;
          r_state  <= w_fast ? DONE : BUSY;
        end
        BUSY: if (i_flush) begin
          r_start <= 1'b0;
          r_state <= IDLE;
        end else if (i_core_ready) begin
          r_res   <= i_core_result;
          r_start <= 1'b0;
          r_state <= DONE;
        end else if (w_tmo) begin
          r_err   <= 1'b1;
          r_res   <= '0;
          r_start <= 1'b0;
          r_state <= DONE;
        end else
          r_cnt <= r_cnt + 1'b1;
        default: if (i_ex_adv || i_flush) r_state <= IDLE;
      endcase
  assign o_core_start  = r_start;
  assign o_core_signed = r_signed;
  assign o_core_a      = r_a;
  assign o_core_b      = r_b;
  assign o_hilo_wdata  = r_res;
  assign o_div_err     = r_err;
  assign o_div_stall   = !rst && (r_state == BUSY || w_go);
  assign o_core_annul  = !rst && r_state == BUSY && (i_flush || w_tmo);
  assign o_hilo_we     = !rst && r_state == DONE && i_ex_adv && !i_flush;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: randomized and directed checks of div_seq_ctrl against a behavioural divider model.
module tb_div_seq_ctrl;
  localparam int MAXC = 40;
  logic        clk = 0, rst = 1;
  logic        op_div = 0, op_signed = 0, flush = 0, ex_adv = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic [63:0] core_result;
  logic        core_ready;
  logic        core_start, core_signed, core_annul, div_stall, hilo_we, div_err;
  logic [31:0] core_a, core_b;
  logic [63:0] hilo_wdata;
  int          checks = 0, failures = 0;
  int          core_lat = 0, core_cnt = 0;
  bit          tie0 = 0;

  div_seq_ctrl #(.WIDTH(32), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .i_op_div(op_div), .i_op_signed(op_signed),
    .i_src_a(src_a), .i_src_b(src_b), .i_flush(flush), .i_ex_adv(ex_adv),
    .i_core_result(core_result), .i_core_ready(core_ready),
    .o_core_start(core_start), .o_core_signed(core_signed), .o_core_a(core_a),
    .o_core_b(core_b), .o_core_annul(core_annul), .o_div_stall(div_stall),
    .o_hilo_we(hilo_we), .o_hilo_wdata(hilo_wdata), .o_div_err(div_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (s) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  // Core model: result valid once core_start has been high for core_lat edges
  always @(posedge clk) core_cnt <= core_start ? core_cnt + 1 : 0;
  assign core_ready  = core_start && !tie0 && core_cnt >= core_lat;
  assign core_result = ref_div(core_a, core_b, core_signed);

  task automatic test_reset(input string nm);
    rst = 1; op_div = 1; src_b = 5; flush = 0; ex_adv = 1;
    repeat (2) @(negedge clk);
    #1 checks++;
    if ({core_start, core_signed, core_a, core_b, core_annul, div_stall, hilo_we, hilo_wdata, div_err} !== '0) begin
      failures++;
      $display("FAIL %s: start=%b sgn=%b a=%h b=%h annul=%b stall=%b we=%b wd=%h err=%b, want all 0",
               nm, core_start, core_signed, core_a, core_b, core_annul, div_stall, hilo_we, hilo_wdata, div_err);
    end
    op_div = 0; ex_adv = 0;
    @(negedge clk); rst = 0;
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int lat,
                        input int hold, input logic [63:0] exp, input string nm);
    int n, st;
    bit fast;
`ifdef DIV_ZERO_FAST_EN
    fast = (b == 0);
`else
    fast = 0;
`endif
    core_lat = lat;
    @(negedge clk); op_div = 1; op_signed = s; src_a = a; src_b = b; flush = 0; ex_adv = 0;
    #1 checks++;
    if (div_stall !== 1'b1 || core_start !== 1'b0) begin
      failures++; $display("FAIL %s detect: stall=%b start=%b want 1/0", nm, div_stall, core_start);
    end
    n = 0; st = 0;
    do begin
      @(negedge clk); src_a = $urandom; src_b = $urandom; #1; n++;
      if (core_start) st++;
      if (div_stall) begin
        checks++;
        if ({core_a, core_b, core_signed} !== {a, b, s}) begin
          failures++; $display("FAIL %s frozen ops: a=%h b=%h s=%b want %h %h %b", nm, core_a, core_b, core_signed, a, b, s);
        end
      end
    end while (div_stall && n < 200);
    checks++;
    if (n != (fast ? 1 : lat + 2)) begin
      failures++; $display("FAIL %s stall length: got %0d want %0d", nm, n, fast ? 1 : lat + 2);
    end
    checks++;
    if (st != (fast ? 0 : lat + 1)) begin
      failures++; $display("FAIL %s core_start cycles: got %0d want %0d", nm, st, fast ? 0 : lat + 1);
    end
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (hilo_we !== 1'b0 || hilo_wdata !== exp || core_start !== 1'b0 || div_stall !== 1'b0) begin
        failures++;
        $display("FAIL %s hold %0d: we=%b wd=%h start=%b stall=%b want 0 %h 0 0", nm, i, hilo_we, hilo_wdata, core_start, div_stall, exp);
      end
      @(negedge clk); #1;
    end
    ex_adv = 1; #1 checks++;
    if (hilo_we !== 1'b1 || hilo_wdata !== exp) begin
      failures++; $display("FAIL %s write: we=%b wd=%h want 1 %h", nm, hilo_we, hilo_wdata, exp);
    end
  endtask

  task automatic idle_check(input string nm);
    @(negedge clk); op_div = 0; ex_adv = 0; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (hilo_we !== 1'b0 || div_stall !== 1'b0 || core_start !== 1'b0 || core_annul !== 1'b0) begin
        failures++; $display("FAIL %s idle: we=%b stall=%b start=%b annul=%b want 0", nm, hilo_we, div_stall, core_start, core_annul);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_directed;
    do_div(32'd7, 32'd2, 1'b1, 3, 0, 64'h00000001_00000003, "div7_2"); idle_check("div7_2");
    do_div(-32'sd7, 32'd2, 1'b1, 2, 1, 64'hFFFFFFFF_FFFFFFFD, "divm7_2"); idle_check("divm7_2");
    do_div(32'hFFFFFFFF, 32'd16, 1'b0, 5, 0, 64'h0000000F_0FFFFFFF, "divu_ff_16"); idle_check("divu_ff_16");
    do_div(32'd100, 32'd9, 1'b0, 1, 3, 64'h00000001_0000000B, "hold3"); idle_check("hold3");
    do_div(32'd5, 32'd0, 1'b0, 2, 1, 64'h00000005_FFFFFFFF, "divu_zero"); idle_check("divu_zero");
  endtask

  task automatic test_back_to_back;
    do_div(32'd20, 32'd6, 1'b0, 0, 0, 64'h00000002_00000003, "b2b_1");
    do_div(32'd9, 32'd4, 1'b1, 1, 1, 64'h00000001_00000002, "b2b_2");
    idle_check("b2b");
  endtask

  task automatic test_flush;
    core_lat = 20;
    @(negedge clk); op_div = 1; op_signed = 0; src_a = 100; src_b = 3; flush = 0; ex_adv = 0;
    repeat (5) @(negedge clk);
    flush = 1; op_div = 0; #1 checks++;
    if (core_annul !== 1'b1 || hilo_we !== 1'b0 || div_stall !== 1'b1) begin
      failures++; $display("FAIL flush cycle: annul=%b we=%b stall=%b want 1 0 1", core_annul, hilo_we, div_stall);
    end
    @(negedge clk); flush = 0; #1 checks++;
    if (div_stall !== 1'b0 || core_annul !== 1'b0 || core_start !== 1'b0) begin
      failures++; $display("FAIL flush after: stall=%b annul=%b start=%b want 0", div_stall, core_annul, core_start);
    end
    idle_check("flush");
  endtask

  task automatic test_watchdog;
    int n, ann;
    tie0 = 1;
    @(negedge clk); op_div = 1; op_signed = 1; src_a = 77; src_b = 7; flush = 0; ex_adv = 0;
    n = 0; ann = -1;
    do begin
      @(negedge clk); #1; n++;
      if (core_annul) ann = n;
    end while (div_stall && n < 200);
    checks++;
    if (n != MAXC + 1 || ann != MAXC) begin
      failures++; $display("FAIL watchdog timing: stall_end=%0d annul_at=%0d want %0d %0d", n, ann, MAXC + 1, MAXC);
    end
    ex_adv = 1; #1 checks++;
    if (div_err !== 1'b1 || hilo_we !== 1'b1 || hilo_wdata !== 64'd0) begin
      failures++; $display("FAIL watchdog result: err=%b we=%b wd=%h want 1 1 0", div_err, hilo_we, hilo_wdata);
    end
    tie0 = 0;
    idle_check("watchdog");
    do_div(32'd8, 32'd3, 1'b0, 1, 0, 64'h00000002_00000002, "after_wd");
    checks++;
    if (div_err !== 1'b1) begin
      failures++; $display("FAIL div_err sticky: got %b want 1", div_err);
    end
    idle_check("after_wd");
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic s;
    for (int k = 0; k < 25; k++) begin
      a = $urandom; b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom; s = 1'($urandom);
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      do_div(a, b, s, $urandom_range(0, 6), $urandom_range(0, 3), ref_div(a, b, s), "rand");
      if ($urandom_range(0, 1) == 1) idle_check("rand");
    end
    idle_check("rand_end");
  endtask

  initial begin
    test_reset("reset");
    test_directed();
    test_back_to_back();
    test_flush();
    test_watchdog();
    test_random();
    test_reset("reset_clears_err");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
